mux_scan: RTL and testbench

Parametrised, registered N-to-1 multiplexer with an automatic channel scanner. It generalises the two-input combinational selector to N_CH channels of WIDTH bits each. It adds a manual-select mode and an auto-scan mode, in which the select steps through all channels, dwelling DWELL cycles on each. It sits between a bank of input sources and a single downstream consumer (display, serial link, logic probe), presenting one channel per cycle with a valid flag and a scan-wrap marker.

---
 rtl/mux_scan.sv | 78 +++++++
 tb/tb_mux_scan.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mux_scan.sv
// mux_scan: registered N-to-1 channel multiplexer with manual select and an auto-scan mode
// that dwells DWELL cycles per channel and pulses wrap on return to channel 0.
module mux_scan #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 2,
    parameter int DWELL = 4,
    localparam int SW   = (N_CH > 2) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] in,
    input  logic                  mode,
    input  logic [SW-1:0]         sel_in,
    input  logic                  en,
    output logic [WIDTH-1:0]      out,
    output logic [SW-1:0]         sel_out,
    output logic                  valid,
    output logic                  wrap
);
    typedef enum logic [1:0] {MANUAL, SCAN, HOLD} state_t;
    localparam logic [SW:0]   NCH  = (SW+1)'(N_CH);
    localparam logic [SW-1:0] LAST = SW'(N_CH - 1);
    localparam logic [7:0]    DEND = 8'(DWELL - 1);
    state_t state, state_nx;
    logic [7:0] dcnt, dcnt_nx;
    logic [SW-1:0] sel_nx;
    logic [WIDTH-1:0] out_nx;
    logic valid_nx, wrap_nx;
    logic [WIDTH-1:0] ch [N_CH];
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign ch[k] = in[k*WIDTH +: WIDTH];
    end
    always_comb begin
        state_nx = !en ? HOLD : mode ? SCAN : MANUAL;
        sel_nx   = sel_out;
        dcnt_nx  = dcnt;
        out_nx   = out;
        valid_nx = valid;
        wrap_nx  = 1'b0;
        if (en && !mode) begin
            sel_nx   = sel_in;
            dcnt_nx  = '0;
            valid_nx = {1'b0, sel_in} < NCH;
            out_nx   = valid_nx ? ch[sel_in] : '0;
        end else if (en) begin
            // entering scan restarts the dwell on the current (legal) channel
            if (state != SCAN) begin
                sel_nx  = ({1'b0, sel_out} < NCH) ? sel_out : '0;
                dcnt_nx = '0;
            end else if (dcnt == DEND) begin
                sel_nx  = (sel_out == LAST) ? '0 : sel_out + 1'b1;
                wrap_nx = sel_out == LAST;
                dcnt_nx = '0;
            end else begin
                dcnt_nx = dcnt + 8'd1;
            end
            out_nx   = ch[sel_nx];
            valid_nx = 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= MANUAL;
            sel_out <= '0;
            dcnt    <= '0;
            out     <= '0;
            valid   <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state   <= state_nx;
            sel_out <= sel_nx;
            dcnt    <= dcnt_nx;
            out     <= out_nx;
            valid   <= valid_nx;
            wrap    <= wrap_nx;
        end
    end
endmodule

// File: tb/tb_mux_scan.sv
// tb_mux_scan: scoreboard bench for mux_scan; a reference model queues expected outputs
// per driven cycle, plus directed checks on N_CH=3 and DWELL=1 instances.
module tb_mux_scan;
    logic clk = 1'b0;
    logic rst_n, mode, en;
    logic [1:0] sel_in;
    logic [7:0] in0;
    logic [5:0] in1 = 6'b10_01_11;
    logic [3:0] in2 = 4'b10_01;
    logic [1:0] out0, sel0, out1, sel1, out2;
    logic [0:0] sel2;
    logic valid0, wrap0, valid1, wrap1, valid2, wrap2;
    int n_chk = 0, n_pass = 0, cyc = 0;

    typedef struct packed {
        logic [1:0] out;
        logic [1:0] sel;
        logic       valid;
        logic       wrap;
    } exp_t;
    exp_t q[$];
    int ms, mdcnt;
    logic [1:0] msel, mout;
    logic mvalid, mwrap;

    always #5 clk = ~clk;

    mux_scan #(.N_CH(4), .WIDTH(2), .DWELL(4)) u0 (
        .clk(clk), .rst_n(rst_n), .in(in0), .mode(mode), .sel_in(sel_in), .en(en),
        .out(out0), .sel_out(sel0), .valid(valid0), .wrap(wrap0));
    mux_scan #(.N_CH(3), .WIDTH(2), .DWELL(4)) u1 (
        .clk(clk), .rst_n(rst_n), .in(in1), .mode(mode), .sel_in(sel_in), .en(en),
        .out(out1), .sel_out(sel1), .valid(valid1), .wrap(wrap1));
    mux_scan #(.N_CH(2), .WIDTH(2), .DWELL(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in(in2), .mode(mode), .sel_in(sel_in[0:0]), .en(en),
        .out(out2), .sel_out(sel2), .valid(valid2), .wrap(wrap2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    endtask

    task automatic model_reset();
        ms = 0; msel = 0; mdcnt = 0; mout = 0; mvalid = 0; mwrap = 0;
        q.delete();
    endtask

    task automatic step(input logic e, input logic m, input logic [1:0] s);
        exp_t x;
        en = e; mode = m; sel_in = s;
        mwrap = 0;
        if (!e) ms = 2;
        else if (!m) begin
            ms = 0; msel = s; mdcnt = 0; mvalid = 1; mout = in0[s*2 +: 2];
        end else begin
            if (ms != 1) mdcnt = 0;
            else if (mdcnt == 3) begin
                mdcnt = 0; mwrap = (msel == 2'd3); msel = msel + 2'd1;
            end else mdcnt++;
            ms = 1; mvalid = 1; mout = in0[msel*2 +: 2];
        end
        x = '{out: mout, sel: msel, valid: mvalid, wrap: mwrap};
        q.push_back(x);
        @(posedge clk); #1; cyc++;
        x = q.pop_front();
        chk("out", 32'(out0), 32'(x.out));
        chk("sel_out", 32'(sel0), 32'(x.sel));
        chk("valid", 32'(valid0), 32'(x.valid));
        chk("wrap", 32'(wrap0), 32'(x.wrap));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int last_wrap, n_wrap;
        rst_n = 0; en = 0; mode = 0; sel_in = 0; in0 = 8'b11_10_01_00;
        model_reset();
        #12;
        chk("rst_out", 32'(out0), 0);
        chk("rst_sel", 32'(sel0), 0);
        chk("rst_valid", 32'(valid0), 0);
        chk("rst_wrap", 32'(wrap0), 0);
        @(negedge clk) rst_n = 1;
        // manual select; pattern makes each channel carry its own index
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 2'(k));
            chk("man_data", 32'(out0), k);
        end
        chk("n3_bad_valid", 32'(valid1), 0);
        chk("n3_bad_out", 32'(out1), 0);
        chk("n3_bad_sel", 32'(sel1), 3);
        // auto-scan for 40 cycles
        last_wrap = -1; n_wrap = 0;
        for (int i = 0; i < 40; i++) begin
            step(1, 1, 2'd3);
            if (i == 0) begin
                chk("n3_entry_sel", 32'(sel1), 0);
                chk("n3_entry_wrap", 32'(wrap1), 0);
                chk("n3_entry_out", 32'(out1), 3);
                chk("n3_entry_valid", 32'(valid1), 1);
            end
            if (i < 8) begin
                chk("d1_sel", 32'(sel2), (i + 1) % 2);
                chk("d1_wrap", 32'(wrap2), i % 2);
            end
            if (wrap0) begin
                chk("wrap_at_ch0", 32'(sel0), 0);
                if (last_wrap >= 0) chk("wrap_gap", cyc - last_wrap, 16);
                last_wrap = cyc; n_wrap++;
            end
        end
        chk("wrap_count", n_wrap, 3);
        // freeze at dcnt=2 on channel 1
        for (int i = 0; i < 64 && !(msel == 2'd1 && mdcnt == 2); i++) step(1, 1, 0);
        chk("hunt_c1", (msel == 2'd1 && mdcnt == 2), 1);
        in0 = 8'b00_00_00_00;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 2'd2);
            chk("hold_sel", 32'(sel0), 1);
            chk("hold_out", 32'(out0), 1);
        end
        in0 = 8'b00_01_10_11;
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0);
            chk("resume_sel", 32'(sel0), 1);
            chk("resume_out", 32'(out0), 2);
        end
        step(1, 1, 0);
        chk("resume_adv", 32'(sel0), 2);
        // async reset mid-dwell on channel 2
        for (int i = 0; i < 64 && !(msel == 2'd2 && mdcnt == 2); i++) step(1, 1, 0);
        chk("hunt_c2", (msel == 2'd2 && mdcnt == 2), 1);
        #3 rst_n = 0;
        #1;
        chk("arst_out", 32'(out0), 0);
        chk("arst_sel", 32'(sel0), 0);
        chk("arst_valid", 32'(valid0), 0);
        chk("arst_wrap", 32'(wrap0), 0);
        model_reset();
        @(negedge clk) rst_n = 1;
        step(1, 0, 2'd2);
        chk("post_rst_man", 32'(out0), 1);
        for (int i = 0; i < 6; i++) step(1, 1, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
